// File: rtl/sccb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sccb_pkg : shared state encoding, ACK/NA bit levels and default device ID
// Rev 1.0
// ----------------------------------------------------------------------------
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ID        = 4'd1,
    ST_ID_ACK    = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_NA  = 4'd8,
    ST_IGNORE    = 4'd9
  } sccb_state_t;

  localparam logic       c_ack_bit           = 1'b0;
  localparam logic       c_na_bit            = 1'b1;
  localparam logic [6:0] c_default_device_id = 7'h21;

endpackage
`default_nettype wire

// File: rtl/sccb_line_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sccb_line_sync : sio_c/sio_d synchronizers, edge pulses and START/STOP detect
// Rev 1.0
// ----------------------------------------------------------------------------
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_q;
  logic                   r_sda_q;
  logic                   w_scl;
  logic                   w_sda;
  logic                   w_sda_rise;
  logic                   w_sda_fall;

  // Flops reset to the idle-bus level so leaving reset never fakes an edge on a quiet bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_q    <= w_scl;
      r_sda_q    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_sda_rise = w_sda & ~r_sda_q;
  assign w_sda_fall = ~w_sda & r_sda_q;

  assign o_scl      = w_scl;
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_q;
  assign o_scl_fall = ~w_scl & r_scl_q;
  assign o_start    = w_sda_fall & w_scl;
  assign o_stop     = w_sda_rise & w_scl;

endmodule
`default_nettype wire

// File: rtl/sccb_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sccb_responder : camera-side SCCB responder mapping bus cycles to a register port
// Rev 1.0
// ----------------------------------------------------------------------------
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEVICE_ID   = c_default_device_id,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sio_c,
  inout  wire        io_sio_d,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy
);

  logic        w_scl;
  logic        w_sda;
  logic        w_scl_rise;
  logic        w_scl_fall;
  logic        w_start;
  logic        w_stop;
  logic [7:0]  w_byte;

  sccb_state_t r_state;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_drive;
  logic        r_first;
  logic [7:0]  r_reg_addr;
  logic [7:0]  r_reg_wdata;
  logic        r_reg_we;
  logic        r_busy;

  sccb_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (i_sio_c),
    .i_sda      (io_sio_d),
    .o_scl      (w_scl),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_byte = {r_shift[6:0], w_sda};

  // Ack states: first scl_fall starts driving low, the next one releases and moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'd0;
      r_drive     <= 1'b0;
      r_first     <= 1'b0;
      r_reg_addr  <= 8'd0;
      r_reg_wdata <= 8'd0;
      r_reg_we    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_reg_we <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_bitcnt <= 3'd0;
        r_drive  <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= ST_ID;
        r_bitcnt <= 3'd0;
        r_drive  <= 1'b0;
        r_busy   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: r_drive <= 1'b0;
          ST_ID: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7)
                r_state <= (w_byte[7:1] == DEVICE_ID) ? ST_ID_ACK : ST_IGNORE;
            end
          end
          ST_ID_ACK: begin
            if (w_scl_fall) begin
              if (!r_drive) begin
                r_drive <= 1'b1;
              end else if (r_shift[0]) begin
                r_state  <= ST_RDATA;
                r_bitcnt <= 3'd0;
                r_shift  <= i_reg_rdata;
                r_drive  <= ~i_reg_rdata[7];
              end else begin
                r_state  <= ST_SUB;
                r_bitcnt <= 3'd0;
                r_drive  <= 1'b0;
              end
            end
          end
          ST_SUB: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_reg_addr <= w_byte;
                r_state    <= ST_SUB_ACK;
              end
            end
          end
          ST_SUB_ACK: begin
            if (w_scl_fall) begin
              if (!r_drive) begin
                r_drive <= 1'b1;
              end else begin
                r_drive  <= 1'b0;
                r_first  <= 1'b1;
                r_bitcnt <= 3'd0;
                r_state  <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_reg_wdata <= w_byte;
                r_reg_we    <= 1'b1;
                r_first     <= 1'b0;
                if (!r_first)
                  r_reg_addr <= r_reg_addr + 8'd1;
                r_state <= ST_WDATA_ACK;
              end
            end
          end
          ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_drive) begin
                r_drive <= 1'b1;
              end else begin
                r_drive  <= 1'b0;
                r_bitcnt <= 3'd0;
                r_state  <= ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            // Bit 7 went out on entry; each fall presents the next bit, the 8th releases.
            if (w_scl_fall) begin
              if (r_bitcnt == 3'd7) begin
                r_drive  <= 1'b0;
                r_bitcnt <= 3'd0;
                r_state  <= ST_RDATA_NA;
              end else begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_shift  <= {r_shift[6:0], 1'b0};
                r_drive  <= ~r_shift[6];
              end
            end
          end
          ST_RDATA_NA: begin
            if (w_scl_rise) begin
              if (w_sda == c_na_bit) begin
                r_state <= ST_IGNORE;
              end else begin
                r_reg_addr <= r_reg_addr + 8'd1;
                r_bitcnt   <= 3'd1;
              end
            end else if (w_scl_fall && (r_bitcnt == 3'd1)) begin
              r_state  <= ST_RDATA;
              r_bitcnt <= 3'd0;
              r_shift  <= i_reg_rdata;
              r_drive  <= ~i_reg_rdata[7];
            end
          end
          ST_IGNORE: r_drive <= 1'b0;
          default: begin
            r_state <= ST_IDLE;
            r_drive <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_sio_d    = (r_drive && (r_state != ST_IDLE) && (r_state != ST_IGNORE)) ? 1'b0 : 1'bz;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_reg_we    = r_reg_we;
  assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sccb_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sccb_responder : bit-banged SCCB master with pull-up against sccb_responder
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sccb_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sio_d;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_we;
  logic       busy;

  logic [7:0] rf  [256];
  logic [7:0] mdl [256];
  logic [7:0] wlog_a [$];
  logic [7:0] wlog_d [$];
  int         drv_cnt = 0;
  int         n_tests = 0;
  int         n_fail  = 0;

  assign sio_d = m_low ? 1'b0 : 1'bz;
  pullup (sio_d);
  assign reg_rdata = rf[reg_addr];

  always #5 clk = ~clk;

  sccb_responder #(
    .DEVICE_ID   (7'h21),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sio_c     (scl),
    .io_sio_d    (sio_d),
    .o_reg_addr  (reg_addr),
    .o_reg_wdata (reg_wdata),
    .o_reg_we    (reg_we),
    .i_reg_rdata (reg_rdata),
    .o_busy      (busy)
  );

  always @(posedge clk) if (reg_we) rf[reg_addr] <= reg_wdata;

  always @(negedge clk) begin
    if (reg_we) begin
      wlog_a.push_back(reg_addr);
      wlog_d.push_back(reg_wdata);
    end
    if (!m_low && sio_d === 1'b0) drv_cnt++;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- master primitives (sio_c period = 32 clk) ----------------
  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    m_low = 1'b0; wclk(8);
    scl = 1'b1;   wclk(8);
    m_low = 1'b1; wclk(8);
    scl = 1'b0;   wclk(8);
  endtask

  task automatic m_stop();
    m_low = 1'b1; wclk(8);
    scl = 1'b1;   wclk(8);
    m_low = 1'b0; wclk(8);
  endtask

  task automatic m_bit(input logic b, output logic s);
    m_low = ~b; wclk(8);
    scl = 1'b1; wclk(8);
    s = sio_d;  wclk(8);
    scl = 1'b0; wclk(8);
  endtask

  task automatic m_wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_rbyte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(ack_bit, s);
  endtask

  // Full write: START, 0x42, sub, n data bytes, optional STOP; nack counts unacked bytes.
  task automatic do_write(input logic [7:0] sub, input logic [7:0] d [4], input int n,
                          input bit stop_after, output int nack);
    logic a;
    nack = 0;
    m_start();
    m_wbyte(8'h42, a); if (a !== 1'b0) nack++;
    m_wbyte(sub, a);   if (a !== 1'b0) nack++;
    for (int i = 0; i < n; i++) begin
      m_wbyte(d[i], a);
      if (a !== 1'b0) nack++;
      mdl[(int'(sub) + i) % 256] = d[i];
    end
    if (stop_after) begin
      m_stop();
      wclk(4);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    wclk(3);
    n_tests++; if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", reg_addr); end
    n_tests++; if (reg_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", reg_wdata); end
    n_tests++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", reg_we); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (sio_d !== 1'b1) begin n_fail++; $display("FAIL reset_sio_d: got %b want 1 (released)", sio_d); end
    rst = 1'b0;
    wclk(8);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_write_basic();
    logic a0, a1, a2;
    int   base = wlog_a.size();
    m_start();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_start: got %b want 1", busy); end
    m_wbyte(8'h42, a0);
    m_wbyte(8'h12, a1);
    m_wbyte(8'h80, a2);
    mdl[8'h12] = 8'h80;
    m_stop();
    wclk(4);
    n_tests++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL wr_acks: got %b want 000", {a0, a1, a2}); end
    n_tests++; if (wlog_a.size() - base !== 1) begin n_fail++; $display("FAIL wr_count: got %0d want 1", wlog_a.size() - base); end
    if (wlog_a.size() > base) begin
      n_tests++; if (wlog_a[base] !== 8'h12) begin n_fail++; $display("FAIL wr_addr: got %h want 12", wlog_a[base]); end
      n_tests++; if (wlog_d[base] !== 8'h80) begin n_fail++; $display("FAIL wr_data: got %h want 80", wlog_d[base]); end
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_write_random();
    logic [7:0] d [4];
    logic [7:0] sub;
    int n, nack, base;
    repeat (4) begin
      sub = 8'($urandom);
      n   = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      base = wlog_a.size();
      do_write(sub, d, n, 1'b1, nack);
      n_tests++; if (nack !== 0) begin n_fail++; $display("FAIL rw_nack sub=%h: got %0d want 0", sub, nack); end
      n_tests++; if (wlog_a.size() - base !== n) begin n_fail++; $display("FAIL rw_count sub=%h: got %0d want %0d", sub, wlog_a.size() - base, n); end
      for (int i = 0; i < n && base + i < wlog_a.size(); i++) begin
        n_tests++;
        if (wlog_a[base+i] !== 8'((int'(sub) + i) % 256) || wlog_d[base+i] !== d[i]) begin
          n_fail++;
          $display("FAIL rw_entry%0d: got %h/%h want %h/%h", i, wlog_a[base+i], wlog_d[base+i], 8'((int'(sub) + i) % 256), d[i]);
        end
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] d [4];
    logic [7:0] rd;
    logic       a, s;
    int         nack, d0;
    d[0] = 8'h76; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
    do_write(8'h0A, d, 1, 1'b1, nack);
    do_write(8'h0A, d, 0, 1'b1, nack);
    m_start();
    m_wbyte(8'h43, a);
    m_rbyte(1'b1, rd);
    n_tests++; if (a !== 1'b0) begin n_fail++; $display("FAIL rd_id_ack: got %b want 0", a); end
    n_tests++; if (rd !== mdl[8'h0A]) begin n_fail++; $display("FAIL rd_data: got %h want %h", rd, mdl[8'h0A]); end
    d0 = drv_cnt;
    for (int i = 0; i < 3; i++) m_bit(1'b1, s);
    n_tests++; if (drv_cnt !== d0) begin n_fail++; $display("FAIL rd_na_ignore_drive: got %0d drives want 0", drv_cnt - d0); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_na_busy: got %b want 1", busy); end
    m_stop();
    wclk(4);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_stop_busy: got %b want 0", busy); end
  endtask

  task automatic test_read_repeated_start();
    logic [7:0] d [4];
    logic [7:0] a0, rd;
    logic       a;
    int         nack;
    a0 = 8'($urandom);
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    do_write(a0, d, 3, 1'b1, nack);
    do_write(a0, d, 0, 1'b0, nack);
    m_start();
    m_wbyte(8'h43, a);
    n_tests++; if (a !== 1'b0) begin n_fail++; $display("FAIL rs_id_ack: got %b want 0", a); end
    for (int i = 0; i < 3; i++) begin
      m_rbyte((i == 2) ? 1'b1 : 1'b0, rd);
      n_tests++;
      if (rd !== mdl[(int'(a0) + i) % 256]) begin
        n_fail++;
        $display("FAIL rs_byte%0d: got %h want %h", i, rd, mdl[(int'(a0) + i) % 256]);
      end
    end
    n_tests++; if (reg_addr !== 8'((int'(a0) + 2) % 256)) begin n_fail++; $display("FAIL rs_addr: got %h want %h", reg_addr, 8'((int'(a0) + 2) % 256)); end
    m_stop();
    wclk(4);
  endtask

  task automatic test_wrong_id();
    logic a0, a1, a2;
    int   base = wlog_a.size();
    int   d0 = drv_cnt;
    m_start();
    m_wbyte(8'h60, a0);
    m_wbyte(8'h12, a1);
    m_wbyte(8'h55, a2);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wid_busy: got %b want 1", busy); end
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL wid_acks: got %b want 111", {a0, a1, a2}); end
    m_stop();
    wclk(4);
    n_tests++; if (wlog_a.size() !== base) begin n_fail++; $display("FAIL wid_we: got %0d writes want 0", wlog_a.size() - base); end
    n_tests++; if (drv_cnt !== d0) begin n_fail++; $display("FAIL wid_drive: got %0d drives want 0", drv_cnt - d0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wid_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] d [4];
    int         nack;
    int         base = wlog_a.size();
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h00; d[3] = 8'h00;
    do_write(8'hFF, d, 2, 1'b1, nack);
    n_tests++; if (wlog_a.size() - base !== 2) begin n_fail++; $display("FAIL wrap_count: got %0d want 2", wlog_a.size() - base); end
    if (wlog_a.size() >= base + 2) begin
      n_tests++; if (wlog_a[base] !== 8'hFF || wlog_d[base] !== 8'h11) begin n_fail++; $display("FAIL wrap_first: got %h/%h want ff/11", wlog_a[base], wlog_d[base]); end
      n_tests++; if (wlog_a[base+1] !== 8'h00 || wlog_d[base+1] !== 8'h22) begin n_fail++; $display("FAIL wrap_second: got %h/%h want 00/22", wlog_a[base+1], wlog_d[base+1]); end
    end
  endtask

  task automatic test_partial();
    logic a, s;
    int   base = wlog_a.size();
    m_start();
    m_wbyte(8'h42, a);
    m_wbyte(8'h20, a);
    for (int i = 0; i < 4; i++) m_bit(1'($urandom), s);
    m_stop();
    wclk(4);
    n_tests++; if (wlog_a.size() !== base) begin n_fail++; $display("FAIL part_we: got %0d writes want 0", wlog_a.size() - base); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL part_busy: got %b want 0", busy); end
    n_tests++; if (reg_addr !== 8'h20) begin n_fail++; $display("FAIL part_addr: got %h want 20", reg_addr); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d [4];
    logic       a;
    int         nack, base;
    d[0] = 8'($urandom) & 8'h7F; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
    do_write(8'h31, d, 1, 1'b1, nack);
    do_write(8'h31, d, 0, 1'b1, nack);
    m_start();
    m_wbyte(8'h43, a);
    n_tests++; if (sio_d !== 1'b0) begin n_fail++; $display("FAIL rmid_drive_bit7: got %b want 0", sio_d); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (sio_d !== 1'b1) begin n_fail++; $display("FAIL rmid_release: got %b want 1", sio_d); end
    n_tests++; if (reg_addr !== 8'h00 || busy !== 1'b0 || reg_we !== 1'b0 || reg_wdata !== 8'h00) begin
      n_fail++; $display("FAIL rmid_outputs: got addr=%h busy=%b we=%b wdata=%h want 00/0/0/00", reg_addr, busy, reg_we, reg_wdata);
    end
    wclk(3);
    rst = 1'b0;
    m_low = 1'b0;
    scl = 1'b1;
    wclk(16);
    base = wlog_a.size();
    d[0] = 8'h5A;
    do_write(8'h44, d, 1, 1'b1, nack);
    n_tests++; if (nack !== 0) begin n_fail++; $display("FAIL rmid_after_nack: got %0d want 0", nack); end
    n_tests++; if (wlog_a.size() - base !== 1) begin n_fail++; $display("FAIL rmid_after_count: got %0d want 1", wlog_a.size() - base); end
    if (wlog_a.size() > base) begin
      n_tests++; if (wlog_a[base] !== 8'h44 || wlog_d[base] !== 8'h5A) begin n_fail++; $display("FAIL rmid_after_write: got %h/%h want 44/5a", wlog_a[base], wlog_d[base]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_random();
    test_read();
    test_read_repeated_start();
    test_wrong_id();
    test_wrap();
    test_partial();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
